// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StCalc,
        StFix,
        StDone
    } div_state_e;

    // Helpers work on a wide container so one package serves every divider width.
    localparam int unsigned MaxW = 64;
    typedef logic [MaxW-1:0] word_t;

    function automatic word_t width_mask(input int unsigned w);
        if (w >= MaxW) begin
            return '1;
        end
        return (word_t'(1) << w) - word_t'(1);
    endfunction

    // Most negative w-bit two's-complement value: {1'b1, {w-1{1'b0}}}.
    function automatic word_t min_w(input int unsigned w);
        return word_t'(1) << (w - 1);
    endfunction

    // Magnitude of a w-bit two's-complement value; MIN maps to 2^(w-1).
    function automatic word_t abs_w(input word_t v, input int unsigned w);
        word_t sign;
        sign = v >> (w - 1);
        if (sign[0]) begin
            return (~v + word_t'(1)) & width_mask(w);
        end
        return v & width_mask(w);
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract, keep or restore.
module div_iter_step
    import div_pkg::*;
#(
    parameter int unsigned W = 21
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);

    logic [W:0] rem_sh;
    logic [W:0] trial;

    always_comb begin
        rem_sh = {rem_i, quo_i[W-1]};
        // rem < divisor on entry, so a clear top bit means the subtraction fit
        trial  = rem_sh - {1'b0, divisor_i};
        if (!trial[W]) begin
            rem_o = trial[W-1:0];
            quo_o = {quo_i[W-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[W-1:0];
            quo_o = {quo_i[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider_ss.sv
// Multi-cycle signed/unsigned restoring divider with valid/ready handshakes,
// one quotient bit per cycle, plus divide-by-zero and signed-overflow flags.
module seq_divider_ss
    import div_pkg::*;
#(
    parameter  int unsigned W  = 21,
    localparam int unsigned CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         in_signed_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] quotient_o,
    output logic [W-1:0] remainder_o,
    output logic         div_by_zero_o,
    output logic         overflow_o
);

    localparam logic [W-1:0] MinPat = W'(min_w(W));

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          sgn_q, sgn_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  bmag_q, bmag_d;
    logic          neg_quo_q, neg_quo_d;
    logic          neg_rem_q, neg_rem_d;
    logic [W-1:0]  quotient_q, quotient_d;
    logic [W-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [W-1:0]  a_abs, b_abs;
    logic [W-1:0]  step_rem, step_quo;

    always_comb begin
        a_abs = W'(abs_w(word_t'(a_q), W));
        b_abs = W'(abs_w(word_t'(b_q), W));
    end

    div_iter_step #(
        .W (W)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (bmag_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sgn_d       = sgn_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        bmag_d      = bmag_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        in_ready_o  = (state_q == StIdle);
        out_valid_o = (state_q == StDone);

        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d     = dividend_i;
                    b_d     = divisor_i;
                    sgn_d   = in_signed_i;
                    state_d = StPrep;
                end
            end
            StPrep: begin
                if (b_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = a_q;
                    dbz_d       = 1'b1;
                    ovf_d       = 1'b0;
                    state_d     = StDone;
                end else if (sgn_q && (a_q == MinPat) && (b_q == '1)) begin
                    quotient_d  = a_q;
                    remainder_d = '0;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b1;
                    state_d     = StDone;
                end else begin
                    quo_d     = sgn_q ? a_abs : a_q;
                    bmag_d    = sgn_q ? b_abs : b_q;
                    neg_quo_d = sgn_q & (a_q[W-1] ^ b_q[W-1]);
                    neg_rem_d = sgn_q & a_q[W-1];
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                quotient_d  = neg_quo_q ? -quo_q : quo_q;
                remainder_d = neg_rem_q ? -rem_q : rem_q;
                dbz_d       = 1'b0;
                ovf_d       = 1'b0;
                state_d     = StDone;
            end
            StDone: begin
                // Returning to idle first keeps accept and output handshake in separate cycles
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            bmag_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sgn_q       <= sgn_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            bmag_q      <= bmag_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_seq_divider_ss.sv
// Self-checking bench for seq_divider_ss: directed cases, back-pressure, random ops, mid-op reset.
module tb_seq_divider_ss;

    localparam int unsigned W = 21;
    localparam int          NormLat = W + 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_divider_ss #(
        .W (W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_signed_i   (in_signed),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (div_by_zero),
        .overflow_o    (overflow)
    );

    // Directed cases: sign mode, dividend, divisor, quotient, remainder, dbz, ovf, latency
    localparam int NDir = 8;
    localparam logic         DS [NDir] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam logic [W-1:0] DA [NDir] = '{21'd100, 21'h1FFFF9, 21'd7, 21'd5, 21'd5,
                                           21'h100000, 21'h100000, 21'h100000};
    localparam logic [W-1:0] DB [NDir] = '{21'd7, 21'd2, 21'h1FFFFE, 21'd0, 21'd0,
                                           21'h1FFFFF, 21'h1FFFFF, 21'd3};
    localparam logic [W-1:0] DQ [NDir] = '{21'd14, 21'h1FFFFD, 21'h1FFFFD, 21'h1FFFFF,
                                           21'h1FFFFF, 21'h100000, 21'd0, 21'h1AAAAB};
    localparam logic [W-1:0] DR [NDir] = '{21'd2, 21'h1FFFFF, 21'd1, 21'd5, 21'd5, 21'd0,
                                           21'h100000, 21'h1FFFFF};
    localparam logic DZ [NDir] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic DO [NDir] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam int   DL [NDir] = '{NormLat, NormLat, NormLat, 1, 1, 1, NormLat, NormLat};

    // Reference model from plain integer arithmetic (SV / and % truncate toward zero).
    function automatic void model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic ov);
        longint sa, sb;
        dz = 1'b0;
        ov = 1'b0;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (sgn && a == 21'h100000 && b == 21'h1FFFFF) begin
            q  = a;
            r  = '0;
            ov = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            sa = longint'(a);
            sb = longint'(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end
    endfunction

    // Drive one request until accepted; operands are scrambled right after the accept edge.
    task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
        end
        in_valid  = 1'b1;
        in_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_signed = 1'($urandom());
        dividend  = W'($urandom());
        divisor   = W'($urandom());
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !==
            {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: rdy=%0b vld=%0b q=%h r=%h dz=%0b ov=%0b required 1 0 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
        end
    endtask

    task automatic test_directed();
        int lat;
        for (int i = 0; i < NDir; i++) begin
            start_op(DS[i], DA[i], DB[i]);
            wait_result(lat);
            n_cmp++;
            if ({quotient, remainder, div_by_zero, overflow} !== {DQ[i], DR[i], DZ[i], DO[i]}) begin
                n_err++;
                $display("FAIL directed_%0d: q=%h r=%h dz=%0b ov=%0b required q=%h r=%h dz=%0b ov=%0b",
                         i, quotient, remainder, div_by_zero, overflow, DQ[i], DR[i], DZ[i], DO[i]);
            end
            n_cmp++;
            if (lat !== DL[i]) begin
                n_err++;
                $display("FAIL directed_latency_%0d: got %0d required %0d", i, lat, DL[i]);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            n_cmp++;
            if ({in_ready, out_valid} !== 2'b10) begin
                n_err++;
                $display("FAIL directed_handshake_%0d: rdy=%0b vld=%0b required 1 0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [W-1:0] eq, er;
        logic edz, eov;
        model(1'b0, 21'd1000, 21'd9, eq, er, edz, eov);
        start_op(1'b0, 21'd1000, 21'd9);
        wait_result(lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({out_valid, in_ready, quotient, remainder, div_by_zero, overflow} !==
                {1'b1, 1'b0, eq, er, edz, eov}) begin
                n_err++;
                $display("FAIL backpressure_hold_%0d: vld=%0b rdy=%0b q=%h r=%h required 1 0 %h %h",
                         c, out_valid, in_ready, quotient, remainder, eq, er);
            end
        end
        // Offer a new request in the handshake cycle; it must not be taken yet.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_signed = 1'b0;
        dividend  = 21'd50;
        divisor   = 21'd5;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder} !== {1'b1, 1'b0, eq, er}) begin
            n_err++;
            $display("FAIL backpressure_release: rdy=%0b vld=%0b q=%h r=%h required 1 0 %h %h",
                     in_ready, out_valid, quotient, remainder, eq, er);
        end
    endtask

    task automatic test_back_to_back();
        int lat, elat;
        logic sgn, edz, eov;
        logic [W-1:0] a, b, eq, er;
        for (int n = 0; n < 1000; n++) begin
            sgn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       b = '0;
                1:       b = '1;
                2:       b = W'(1);
                3:       b = W'($urandom_range(1, 15));
                default: b = W'($urandom());
            endcase
            case ($urandom_range(0, 5))
                0:       a = 21'h100000;
                1:       a = W'($urandom_range(0, 63));
                default: a = W'($urandom());
            endcase
            model(sgn, a, b, eq, er, edz, eov);
            elat = (edz || eov) ? 1 : NormLat;
            start_op(sgn, a, b);
            wait_result(lat);
            n_cmp++;
            if ({quotient, remainder, div_by_zero, overflow} !== {eq, er, edz, eov}) begin
                n_err++;
                $display("FAIL random_%0d s=%0b %h/%h: q=%h r=%h dz=%0b ov=%0b required %h %h %0b %0b",
                         n, sgn, a, b, quotient, remainder, div_by_zero, overflow,
                         eq, er, edz, eov);
            end
            n_cmp++;
            if (lat !== elat) begin
                n_err++;
                $display("FAIL random_latency_%0d: got %0d required %0d", n, lat, elat);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen_valid = 1'b0;
        start_op(1'b0, 21'h1ABCDE, 21'd3);
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !==
            {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid_state: rdy=%0b vld=%0b q=%h r=%h dz=%0b ov=%0b required 1 0 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
        end
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        n_cmp++;
        if (seen_valid) begin
            n_err++;
            $display("FAIL reset_mid_no_result: out_valid seen=1 required 0");
        end
        start_op(1'b0, 21'h1FFFFF, 21'd1);
        wait_result(lat);
        n_cmp++;
        if ({quotient, remainder, div_by_zero, overflow, lat} !==
            {21'h1FFFFF, 21'd0, 1'b0, 1'b0, NormLat}) begin
            n_err++;
            $display("FAIL reset_mid_recover: q=%h r=%h dz=%0b ov=%0b lat=%0d required 1fffff 0 0 0 %0d",
                     quotient, remainder, div_by_zero, overflow, lat, NormLat);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
